// File: rtl/scumvcontroller_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmit byte stream among the
// ASC response, STL response and debug/status sources. Whole packets are
// granted, optionally prefixed with a one-byte source tag, and a packet whose
// source stalls for too long mid-packet is aborted.
module scumvcontroller_tx_arbiter #(
    parameter bit          TAG_EN         = 1'b1,
    parameter logic [7:0]  TAG_ASC        = 8'h61,
    parameter logic [7:0]  TAG_STL        = 8'h73,
    parameter logic [7:0]  TAG_DBG        = 8'h64,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  src_valid,
    input  logic [23:0] src_data,
    input  logic [2:0]  src_last,
    output logic [2:0]  src_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  timeout_src,
    input  logic        err_clear
);

    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    // Last stall-counter value tolerated before the packet is aborted.
    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  grant_next;
    logic [1:0]  gidx, gidx_next;       // index of the granted source
    logic [1:0]  rr_ptr, rr_next;       // first source considered at next arbitration
    logic [23:0] cnt, cnt_next;         // consecutive source-stall cycles in DATA
    logic        err_next;
    logic [1:0]  tsrc_next;
    logic [1:0]  pick;
    logic        cur_valid;
    logic        cur_last;
    logic [7:0]  cur_data;
    logic [7:0]  tag_byte;

    // First requesting source at or after ptr in cyclic order 0,1,2.
    // Scanning from the farthest offset down lets the nearest hit win.
    function automatic logic [1:0] pick_src(input logic [2:0] req, input logic [1:0] ptr);
        int         s;
        logic [1:0] idx;
        pick_src = ptr;
        for (int k = 2; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= 3) s = s - 3;
            idx = 2'(s);
            if (req[idx]) pick_src = idx;
        end
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] g);
        next_idx = (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    assign pick      = pick_src(src_valid, rr_ptr);
    assign cur_valid = src_valid[gidx];
    assign cur_last  = src_last[gidx];
    assign cur_data  = src_data[{gidx, 3'b000} +: 8];
    assign busy      = (state != IDLE);

    always_comb begin
        case (gidx)
            2'd0:    tag_byte = TAG_ASC;
            2'd1:    tag_byte = TAG_STL;
            default: tag_byte = TAG_DBG;
        endcase
    end

    // Next-state, register updates and the combinational UART/source handshake.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        grant_next = grant;
        gidx_next  = gidx;
        rr_next    = rr_ptr;
        cnt_next   = cnt;
        err_next   = timeout_err & ~err_clear;
        tsrc_next  = timeout_src;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        src_ready  = 3'b000;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (|src_valid) begin
                    gidx_next  = pick;
                    grant_next = 3'(3'b001 << pick);
                    state_next = TAG_EN ? TAG : DATA;
                end
            end
            TAG: begin
                tx_valid = 1'b1;
                tx_data  = tag_byte;
                cnt_next = '0;
                if (tx_ready) state_next = DATA;
            end
            DATA: begin
                tx_valid        = cur_valid;
                tx_data         = cur_data;
                src_ready[gidx] = tx_ready;
                if (cur_valid && tx_ready) begin
                    cnt_next = '0;
                    if (cur_last) begin
                        state_next = IDLE;
                        grant_next = 3'b000;
                        rr_next    = next_idx(gidx);
                    end
                end else if (!cur_valid) begin
                    // Only a silent source counts as a stall; UART backpressure does not.
                    if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        grant_next = 3'b000;
                        rr_next    = next_idx(gidx);
                        cnt_next   = '0;
                        err_next   = 1'b1;
                        tsrc_next  = gidx;
                    end else begin
                        cnt_next = cnt + 24'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 3'b000;
            gidx        <= 2'd0;
            rr_ptr      <= 2'd0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            timeout_src <= 2'd0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            gidx        <= gidx_next;
            rr_ptr      <= rr_next;
            cnt         <= cnt_next;
            timeout_err <= err_next;
            timeout_src <= tsrc_next;
        end
    end

endmodule

// File: doc/scumvcontroller_tx_arbiter.md
Name: scumvcontroller_tx_arbiter

Overview:
- Shares the single UART transmit byte stream among three response sources: ASC response, STL response, and the debug/status reporter.
- Grants whole packets round-robin, optionally prefixes each packet with a one-byte source tag so the host can demultiplex, and aborts stalled packets via an inter-byte timeout.
- Sits between the subsystem response FIFOs and the UART transmitter `data_in` handshake inside the controller top level.

Parameters:
- TAG_EN, 1: 1 = emit a tag byte before each packet; 0 = pass packets untagged.
- TAG_ASC, 8'h61: tag for source 0 (ASC, 'a').
- TAG_STL, 8'h73: tag for source 1 (STL, 's').
- TAG_DBG, 8'h64: tag for source 2 (debug, 'd').
- TIMEOUT_CYCLES, 100000: idle cycles tolerated mid-packet before abort. Minimum 2. Counter is 24 bits wide.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- src_valid  in  3  per-source byte valid (bit0 ASC, bit1 STL, bit2 DBG).
- src_data  in  24  per-source byte, source i on [8i+7:8i].
- src_last  in  3  per-source final-byte-of-packet flag, qualified by src_valid.
- src_ready  out  3  per-source byte accepted when src_valid & src_ready.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  byte valid to UART.
- tx_ready  in  1  UART transmitter ready.
- grant  out  3  one-hot current owner; 0 when idle.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky abort flag.
- timeout_src  out  2  source index of the most recent abort.
- err_clear  in  1  clears timeout_err.

Behaviour:
- Reset (reset_n low at a clock edge) forces the following, regardless of the state at the time (mid-packet included):
  - state IDLE, grant 0, busy 0, src_ready 0, tx_valid 0, tx_data 0;
  - rr_ptr 0, timeout counter 0, timeout_err 0, timeout_src 0.
- States: IDLE, TAG, DATA.
- IDLE:
  - tx_valid 0, src_ready 0.
  - If any src_valid is high: pick the first requesting source at or after rr_ptr (cyclic order 0,1,2), register grant.
  - Next state is TAG (TAG_EN=1) or DATA (TAG_EN=0).
  - Latency: request at cycle N → grant visible at N+1 → first tx_valid at N+1.
- TAG:
  - tx_valid=1, tx_data=tag of granted source, src_ready=0.
  - On tx_ready go to DATA.
  - Timeout counter is held at 0.
- DATA (combinational passthrough for granted source g):
  - tx_valid=src_valid[g], tx_data=src_data[g], src_ready[g]=tx_ready; other src_ready bits 0.
  - Byte accepted when src_valid[g] & tx_ready.
  - Accepted byte with src_last[g]=1: go to IDLE, rr_ptr ← (g+1) mod 3, grant cleared.
  - Timeout counter: cleared on each accepted byte; incremented each cycle src_valid[g]=0; not incremented while src_valid[g]=1 and tx_ready=0, since UART backpressure is not a source stall.
  - Counter reaching TIMEOUT_CYCLES-1 with src_valid[g] still 0 is an abort:
    - next cycle IDLE, timeout_err ← 1, timeout_src ← g, rr_ptr ← (g+1) mod 3;
    - no byte is emitted for the aborted remainder.
- Single-byte packet (src_last on the first data byte): TAG → DATA → IDLE, i.e. 2 UART bytes with TAG_EN=1.
- Back-to-back packets: one IDLE cycle between packets (no tx_valid). Fairness is preferred over bandwidth.
- Requests from non-granted sources are ignored until IDLE. A source holding valid without a grant is not an error.
- src_valid dropping during TAG does not cancel the tag. The packet proceeds to DATA and the timeout then applies.
- err_clear has priority below a same-cycle abort: an abort in the same cycle leaves timeout_err=1.
- timeout_src holds its value until the next abort.
- Output registers: grant, state, rr_ptr, counter, error flags. tx_valid, tx_data and src_ready are combinational from state and grant.

Test Plan:
- Reset/idle: reset_n low 3 cycles then high, no requests → grant=0, busy=0, tx_valid=0, timeout_err=0.
- Single ASC response: src_valid[0] with byte 8'h01, last=1, tx_ready=1 → tx stream 61, 01. busy high exactly 2 cycles, then grant 0, rr_ptr=1.
- Round-robin contention: all three sources request simultaneously; STL sends a 16-byte packet 00..0F; ASC and DBG send 1-byte packets → order ASC (61 xx), STL (73 00..0F), DBG (64 xx). No interleaving, one idle cycle between packets.
- Backpressure: STL packet with tx_ready toggling 1/0 every cycle and TIMEOUT_CYCLES=8 → all 17 bytes delivered in order, no abort, src_ready[1] mirrors tx_ready.
- Timeout:
  - With TIMEOUT_CYCLES=8, DBG sends 3 bytes (no last) then drops valid → abort after 8 stall cycles, timeout_err=1, timeout_src=2, grant=0.
  - A waiting ASC request is then granted next.
  - err_clear pulse → timeout_err=0.
- TAG_EN=0 and mid-packet reset: untagged STL packet passes bytes only; reset_n asserted after byte 5 → all outputs return to reset values next cycle, and the subsequent ASC request is granted first (rr_ptr=0).
